// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Two-host arbiter in front of a daisy-chained register bus. Each host (A, B)
// owns a one-entry request slot. A round-robin FSM takes one slot at a time:
// it issues the request into the head of the chain for one cycle, then waits
// for the chain tail to return, then hands the response back to the owner.
//
// Optional feature (compile-time macro BUS_ARBITER_TIMEOUT_EN):
//   When defined, a transaction still waiting for the chain after TIMEOUT
//   cycles is abandoned. The owner then gets rdata = 0 with rerr = 1.
//   When undefined, the arbiter waits for the chain indefinitely and rerr
//   is tied low.
//
// Parameters
//   TIMEOUT      WAIT cycles before abandoning a transaction (1..65535)
//   RESET_GRANT  port treated as last granted out of reset (0 = A, 1 = B)
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   x_addr_i/x_wdata_i/x_rw_i        host request (x = a, b); rw 1 = write
//   x_valid_i / x_ready_o            request handshake; ready = slot empty
//   x_rdata_o/x_rvalid_o/x_rerr_o    response data, one-cycle strobe, timeout
//   addr_o/wdata_o/rdata_o/rw_o/valid_o  request into the head of the chain
//   addr_i/wdata_i/rdata_i/rw_i/valid_i  return from the tail of the chain
// -----------------------------------------------------------------------------
module bus_arbiter #(
   parameter int unsigned TIMEOUT     = 255,
   parameter bit          RESET_GRANT = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   // host A
   input  logic [15:0] a_addr_i,
   input  logic [15:0] a_wdata_i,
   input  logic        a_rw_i,
   input  logic        a_valid_i,
   output logic        a_ready_o,
   output logic [15:0] a_rdata_o,
   output logic        a_rvalid_o,
   output logic        a_rerr_o,
   // host B
   input  logic [15:0] b_addr_i,
   input  logic [15:0] b_wdata_i,
   input  logic        b_rw_i,
   input  logic        b_valid_i,
   output logic        b_ready_o,
   output logic [15:0] b_rdata_o,
   output logic        b_rvalid_o,
   output logic        b_rerr_o,
   // head of register-bus chain
   output logic [15:0] addr_o,
   output logic [15:0] wdata_o,
   output logic [15:0] rdata_o,
   output logic        rw_o,
   output logic        valid_o,
   // tail of register-bus chain
   input  logic [15:0] addr_i,
   input  logic [15:0] wdata_i,
   input  logic [15:0] rdata_i,
   input  logic        rw_i,
   input  logic        valid_i
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_WAIT    = 2'd2,
      S_RESPOND = 2'd3
   } state_t;

   state_t      r_state, w_state_next;
   logic        r_grant, w_grant_next;   // 0 = A, 1 = B
   logic        r_last;                  // port granted most recently

   logic        r_a_pend, r_b_pend;
   logic [15:0] r_a_addr, r_a_wdata, r_b_addr, r_b_wdata;
   logic        r_a_rw, r_b_rw;

   logic [15:0] r_addr, r_wdata;
   logic        r_rw;
   logic [15:0] r_rdata;

   logic        w_load, w_capture;
   logic        w_respond, w_a_done, w_b_done;
   logic        w_a_accept, w_b_accept;

   // The forwarded address/data/rw from the chain tail carry no information
   // the arbiter needs; only valid_i and rdata_i are used.
   logic        w_unused;
   assign w_unused = ^{addr_i, wdata_i, rw_i, 16'(TIMEOUT)};

   // Slot handshake. The owner's slot frees in its RESPOND cycle, so ready is
   // already high while rvalid pulses and a back-to-back request is accepted.
   assign w_respond  = (r_state == S_RESPOND);
   assign w_a_done   = w_respond && !r_grant;
   assign w_b_done   = w_respond &&  r_grant;
   assign a_ready_o  = !r_a_pend || w_a_done;
   assign b_ready_o  = !r_b_pend || w_b_done;
   assign w_a_accept = a_valid_i && a_ready_o;
   assign w_b_accept = b_valid_i && b_ready_o;

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_pend  <= 1'b0;
         r_a_addr  <= '0;
         r_a_wdata <= '0;
         r_a_rw    <= 1'b0;
      end else if (w_a_accept) begin
         r_a_pend  <= 1'b1;
         r_a_addr  <= a_addr_i;
         r_a_wdata <= a_wdata_i;
         r_a_rw    <= a_rw_i;
      end else if (w_a_done) begin
         r_a_pend  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_b_pend  <= 1'b0;
         r_b_addr  <= '0;
         r_b_wdata <= '0;
         r_b_rw    <= 1'b0;
      end else if (w_b_accept) begin
         r_b_pend  <= 1'b1;
         r_b_addr  <= b_addr_i;
         r_b_wdata <= b_wdata_i;
         r_b_rw    <= b_rw_i;
      end else if (w_b_done) begin
         r_b_pend  <= 1'b0;
      end
   end

`ifdef BUS_ARBITER_TIMEOUT_EN
   logic [15:0] r_tcnt;
   logic        r_rerr;
   logic        w_expire;
   logic        w_tc_hit;

   // The counter holds the number of WAIT cycles already spent, so the
   // TIMEOUT-th WAIT cycle without a return is the expiry cycle.
   assign w_tc_hit = (r_tcnt == 16'(TIMEOUT - 1));
`endif

   // NOTE: every signal assigned here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      w_state_next = r_state;
      w_grant_next = r_grant;
      w_load       = 1'b0;
      w_capture    = 1'b0;
`ifdef BUS_ARBITER_TIMEOUT_EN
      w_expire     = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (r_a_pend || r_b_pend) begin
               w_state_next = S_ISSUE;
               w_load       = 1'b1;
               // Both pending: round-robin away from the last grant.
               w_grant_next = (r_a_pend && r_b_pend) ? !r_last : r_b_pend;
            end
         end
         S_ISSUE: begin
            w_state_next = S_WAIT;
         end
         S_WAIT: begin
            // A return coinciding with expiry is a normal response.
            if (valid_i) begin
               w_capture    = 1'b1;
               w_state_next = S_RESPOND;
            end
`ifdef BUS_ARBITER_TIMEOUT_EN
            else if (w_tc_hit) begin
               w_expire     = 1'b1;
               w_state_next = S_RESPOND;
            end
`endif
         end
         S_RESPOND: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_grant <= RESET_GRANT;
         r_last  <= RESET_GRANT;
      end else begin
         r_state <= w_state_next;
         r_grant <= w_grant_next;
         if (w_respond) r_last <= r_grant;
      end
   end

   // Bus request registers load only when a grant is made and otherwise hold,
   // so the chain sees stable values outside the ISSUE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_rw    <= 1'b0;
      end else if (w_load) begin
         r_addr  <= w_grant_next ? r_b_addr  : r_a_addr;
         r_wdata <= w_grant_next ? r_b_wdata : r_a_wdata;
         r_rw    <= w_grant_next ? r_b_rw    : r_a_rw;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= '0;
      end else if (w_capture) begin
         r_rdata <= rdata_i;
      end
`ifdef BUS_ARBITER_TIMEOUT_EN
      else if (w_expire) begin
         r_rdata <= '0;
      end
`endif
   end

`ifdef BUS_ARBITER_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tcnt <= '0;
         r_rerr <= 1'b0;
      end else begin
         if (r_state == S_WAIT && w_state_next == S_WAIT) r_tcnt <= r_tcnt + 16'd1;
         else                                           r_tcnt <= '0;
         if (w_capture)     r_rerr <= 1'b0;
         else if (w_expire) r_rerr <= 1'b1;
      end
   end

   assign a_rerr_o = w_a_done && r_rerr;
   assign b_rerr_o = w_b_done && r_rerr;
`else
   assign a_rerr_o = 1'b0;
   assign b_rerr_o = 1'b0;
`endif

   // Response outputs are driven only in the owner's RESPOND cycle.
   assign a_rvalid_o = w_a_done;
   assign b_rvalid_o = w_b_done;
   assign a_rdata_o  = w_a_done ? r_rdata : 16'h0000;
   assign b_rdata_o  = w_b_done ? r_rdata : 16'h0000;

   assign addr_o  = r_addr;
   assign wdata_o = r_wdata;
   assign rw_o    = r_rw;
   assign rdata_o = 16'h0000;
   assign valid_o = (r_state == S_ISSUE);

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Scoreboard bench for bus_arbiter. Expected chain requests and per-host
// responses are queued when stimulus is driven, and popped and compared by a
// monitor when the DUT produces them. A small chain model answers each
// request after a programmable latency. The timeout scenario is built only
// when BUS_ARBITER_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] a_addr_i, a_wdata_i, b_addr_i, b_wdata_i;
   logic        a_rw_i, a_valid_i, b_rw_i, b_valid_i;
   logic        a_ready_o, a_rvalid_o, a_rerr_o;
   logic        b_ready_o, b_rvalid_o, b_rerr_o;
   logic [15:0] a_rdata_o, b_rdata_o;
   logic [15:0] addr_o, wdata_o, rdata_o;
   logic        rw_o, valid_o;
   logic [15:0] addr_i, wdata_i, rdata_i;
   logic        rw_i, valid_i;

   always #5 clk = ~clk;

   bus_arbiter #(.TIMEOUT(8), .RESET_GRANT(1'b1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_addr_i  (a_addr_i),
      .a_wdata_i (a_wdata_i),
      .a_rw_i    (a_rw_i),
      .a_valid_i (a_valid_i),
      .a_ready_o (a_ready_o),
      .a_rdata_o (a_rdata_o),
      .a_rvalid_o(a_rvalid_o),
      .a_rerr_o  (a_rerr_o),
      .b_addr_i  (b_addr_i),
      .b_wdata_i (b_wdata_i),
      .b_rw_i    (b_rw_i),
      .b_valid_i (b_valid_i),
      .b_ready_o (b_ready_o),
      .b_rdata_o (b_rdata_o),
      .b_rvalid_o(b_rvalid_o),
      .b_rerr_o  (b_rerr_o),
      .addr_o    (addr_o),
      .wdata_o   (wdata_o),
      .rdata_o   (rdata_o),
      .rw_o      (rw_o),
      .valid_o   (valid_o),
      .addr_i    (addr_i),
      .wdata_i   (wdata_i),
      .rdata_i   (rdata_i),
      .rw_i      (rw_i),
      .valid_i   (valid_i)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   typedef struct packed {
      logic [15:0] rdata;
      logic        rerr;
   } resp_t;

   typedef struct packed {
      logic        rw;
      logic [15:0] addr;
      logic [15:0] wdata;
   } issue_t;

   resp_t  q_a[$];
   resp_t  q_b[$];
   issue_t q_iss[$];
   int     iss_cyc_q[$];

   // Chain model: every register returns a value derived from its address.
   function automatic logic [15:0] chain_rd(input logic [15:0] addr);
      return (addr == 16'h0012) ? 16'hBEEF : (addr ^ 16'h5A5A);
   endfunction

   // ---------------------------------------------------------------- monitor
   int     a_rv_cyc = -1;
   int     b_rv_cyc = -1;
   int     vi_cyc   = -1;
   issue_t e_iss;
   resp_t  e_resp;

   always @(negedge clk) begin
      if (rst_n) begin
         if (valid_o) begin
            iss_cyc_q.push_back(cyc);
            if (q_iss.size() == 0) check("unexpected_issue", 1, 0);
            else begin
               e_iss = q_iss.pop_front();
               check("issue_rw",    rw_o,    e_iss.rw);
               check("issue_addr",  addr_o,  e_iss.addr);
               check("issue_wdata", wdata_o, e_iss.wdata);
               check("issue_rdata", rdata_o, 16'h0000);
            end
         end
         if (a_rvalid_o) begin
            a_rv_cyc = cyc;
            if (q_a.size() == 0) check("unexpected_a_rvalid", 1, 0);
            else begin
               e_resp = q_a.pop_front();
               check("a_rdata", a_rdata_o, e_resp.rdata);
               check("a_rerr",  a_rerr_o,  e_resp.rerr);
               check("a_ready_at_resp", a_ready_o, 1);
            end
         end
         if (b_rvalid_o) begin
            b_rv_cyc = cyc;
            if (q_b.size() == 0) check("unexpected_b_rvalid", 1, 0);
            else begin
               e_resp = q_b.pop_front();
               check("b_rdata", b_rdata_o, e_resp.rdata);
               check("b_rerr",  b_rerr_o,  e_resp.rerr);
               check("b_ready_at_resp", b_ready_o, 1);
            end
         end
         if (a_rvalid_o && b_rvalid_o) check("both_rvalid", 1, 0);
      end
   end

   // ---------------------------------------------------------- chain model
   bit          chain_en = 1'b1;
   int          lat      = 3;
   bit          spur_req = 1'b0;
   logic [15:0] ch_addr;

   initial begin
      valid_i = 1'b0;
      rdata_i = '0;
      addr_i  = '0;
      wdata_i = '0;
      rw_i    = 1'b0;
      forever begin
         @(negedge clk);
         if (spur_req) begin
            spur_req = 1'b0;
            valid_i  = 1'b1;
            rdata_i  = 16'hDEAD;
            @(negedge clk);
            valid_i  = 1'b0;
         end else if (chain_en && rst_n && valid_o) begin
            ch_addr = addr_o;
            repeat (lat) @(negedge clk);
            valid_i = 1'b1;
            rdata_i = chain_rd(ch_addr);
            addr_i  = ch_addr;
            vi_cyc  = cyc;
            @(negedge clk);
            valid_i = 1'b0;
         end
      end
   end

   // ------------------------------------------------------------ host tasks
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_ready(input bit port);
      int b = 0;
      while (!(port ? b_ready_o : a_ready_o) && b < 200) begin
         step();
         b++;
      end
      if (b >= 200) check("ready_wait_expired", 0, 1);
   endtask

   task automatic drive(input bit port, input bit rw, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rd,
                        input bit exp_err);
      if (port) begin
         b_rw_i = rw; b_addr_i = addr; b_wdata_i = wdata; b_valid_i = 1'b1;
         q_b.push_back('{rdata: exp_rd, rerr: exp_err});
      end else begin
         a_rw_i = rw; a_addr_i = addr; a_wdata_i = wdata; a_valid_i = 1'b1;
         q_a.push_back('{rdata: exp_rd, rerr: exp_err});
      end
   endtask

   task automatic release_hosts();
      step();
      a_valid_i = 1'b0;
      b_valid_i = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int b = 0;
      while ((q_a.size() != 0 || q_b.size() != 0 || q_iss.size() != 0) && b < budget) begin
         step();
         b++;
      end
      if (b >= budget) check("drain_wait_expired", 0, 1);
      step();
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_a_ready"},  a_ready_o,  1);
      check({tag, "_b_ready"},  b_ready_o,  1);
      check({tag, "_a_rvalid"}, a_rvalid_o, 0);
      check({tag, "_b_rvalid"}, b_rvalid_o, 0);
      check({tag, "_a_rerr"},   a_rerr_o,   0);
      check({tag, "_b_rerr"},   b_rerr_o,   0);
      check({tag, "_a_rdata"},  a_rdata_o,  0);
      check({tag, "_b_rdata"},  b_rdata_o,  0);
      check({tag, "_valid_o"},  valid_o,    0);
      check({tag, "_rw_o"},     rw_o,       0);
      check({tag, "_addr_o"},   addr_o,     0);
      check({tag, "_wdata_o"},  wdata_o,    0);
      check({tag, "_rdata_o"},  rdata_o,    0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      q_a.delete();
      q_b.delete();
      q_iss.delete();
      reset_checks("reset");
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // --------------------------------------------------------------- sequence
   int acc;

   initial begin
      a_addr_i = '0; a_wdata_i = '0; a_rw_i = 1'b0; a_valid_i = 1'b0;
      b_addr_i = '0; b_wdata_i = '0; b_rw_i = 1'b0; b_valid_i = 1'b0;
      step();
      do_reset();

      // Simultaneous requests out of reset: last grant is B, so A goes first.
      iss_cyc_q.delete();
      q_iss.push_back('{rw: 1'b0, addr: 16'h0100, wdata: 16'h0000});
      q_iss.push_back('{rw: 1'b0, addr: 16'h0200, wdata: 16'h0000});
      acc = cyc;
      drive(1'b0, 1'b0, 16'h0100, 16'h0000, chain_rd(16'h0100), 1'b0);
      drive(1'b1, 1'b0, 16'h0200, 16'h0000, chain_rd(16'h0200), 1'b0);
      release_hosts();
      wait_drain(100);
      check("rr1_a_before_b", (a_rv_cyc < b_rv_cyc), 1);
      check("rr1_first_issue_latency", iss_cyc_q[0] - acc, 2);
      check("rr1_b_issue_after_a_resp", iss_cyc_q[1] - a_rv_cyc, 2);

      // Single A read of 0x0012; chain answers 3 cycles after valid_o.
      iss_cyc_q.delete();
      wait_ready(1'b0);
      q_iss.push_back('{rw: 1'b0, addr: 16'h0012, wdata: 16'h0000});
      acc = cyc;
      drive(1'b0, 1'b0, 16'h0012, 16'h0000, 16'hBEEF, 1'b0);
      release_hosts();
      wait_drain(100);
      check("rd_issue_latency", iss_cyc_q[0] - acc, 2);
      check("rd_resp_latency", a_rv_cyc - iss_cyc_q[0], 4);
      check("rd_resp_after_valid_i", a_rv_cyc - vi_cyc, 1);
      check("rd_a_ready_after", a_ready_o, 1);

      // Last grant is now A, so a simultaneous pair goes B then A.
      iss_cyc_q.delete();
      q_iss.push_back('{rw: 1'b0, addr: 16'h0301, wdata: 16'h0000});
      q_iss.push_back('{rw: 1'b0, addr: 16'h0402, wdata: 16'h0000});
      drive(1'b0, 1'b0, 16'h0402, 16'h0000, chain_rd(16'h0402), 1'b0);
      drive(1'b1, 1'b0, 16'h0301, 16'h0000, chain_rd(16'h0301), 1'b0);
      release_hosts();
      wait_drain(100);
      check("rr2_b_before_a", (b_rv_cyc < a_rv_cyc), 1);

      // B write; response only after the chain returns, bus values hold.
      wait_ready(1'b1);
      q_iss.push_back('{rw: 1'b1, addr: 16'h0003, wdata: 16'h00FF});
      drive(1'b1, 1'b1, 16'h0003, 16'h00FF, chain_rd(16'h0003), 1'b0);
      release_hosts();
      wait_drain(100);
      check("wr_resp_after_valid_i", b_rv_cyc - vi_cyc, 1);
      check("wr_hold_addr",  addr_o,  16'h0003);
      check("wr_hold_wdata", wdata_o, 16'h00FF);
      check("wr_hold_rw",    rw_o,    1);
      check("wr_idle_valid", valid_o, 0);

      // Stray valid_i while idle must not produce a response.
      spur_req = 1'b1;
      repeat (5) step();
      check("spur_a_ready", a_ready_o, 1);
      check("spur_b_ready", b_ready_o, 1);

      // A accepted during B's RESPOND is served in the next IDLE.
      iss_cyc_q.delete();
      q_iss.push_back('{rw: 1'b0, addr: 16'h0077, wdata: 16'h0000});
      q_iss.push_back('{rw: 1'b1, addr: 16'h0088, wdata: 16'h1234});
      drive(1'b1, 1'b0, 16'h0077, 16'h0000, chain_rd(16'h0077), 1'b0);
      release_hosts();
      begin
         int b = 0;
         while (!b_rvalid_o && b < 100) begin
            step();
            b++;
         end
         if (b >= 100) check("b_rvalid_wait_expired", 0, 1);
      end
      check("b2b_a_ready_in_b_resp", a_ready_o, 1);
      drive(1'b0, 1'b1, 16'h0088, 16'h1234, chain_rd(16'h0088), 1'b0);
      release_hosts();
      wait_drain(100);
      check("b2b_a_issue", iss_cyc_q[1] - b_rv_cyc, 2);

`ifdef BUS_ARBITER_TIMEOUT_EN
      // Chain silent: abandoned after 8 WAIT cycles with rerr, then recovery.
      chain_en = 1'b0;
      iss_cyc_q.delete();
      q_iss.push_back('{rw: 1'b0, addr: 16'h0040, wdata: 16'h0000});
      drive(1'b0, 1'b0, 16'h0040, 16'h0000, 16'h0000, 1'b1);
      release_hosts();
      wait_drain(100);
      check("to_resp_latency", a_rv_cyc - iss_cyc_q[0], 9);
      chain_en = 1'b1;
      q_iss.push_back('{rw: 1'b0, addr: 16'h0041, wdata: 16'h0000});
      drive(1'b0, 1'b0, 16'h0041, 16'h0000, chain_rd(16'h0041), 1'b0);
      release_hosts();
      wait_drain(100);
`endif

      // Reset during WAIT; a late return after release must be ignored.
      chain_en = 1'b0;
      q_iss.push_back('{rw: 1'b0, addr: 16'h0050, wdata: 16'h0000});
      drive(1'b0, 1'b0, 16'h0050, 16'h0000, chain_rd(16'h0050), 1'b0);
      release_hosts();
      begin
         int b = 0;
         while (q_iss.size() != 0 && b < 50) begin
            step();
            b++;
         end
         if (b >= 50) check("issue_wait_expired", 0, 1);
      end
      repeat (3) step();
      do_reset();
      spur_req = 1'b1;
      repeat (5) step();
      reset_checks("post_reset");
      chain_en = 1'b1;

      // Normal service after reset.
      q_iss.push_back('{rw: 1'b0, addr: 16'h0099, wdata: 16'h0000});
      drive(1'b1, 1'b0, 16'h0099, 16'h0000, chain_rd(16'h0099), 1'b0);
      release_hosts();
      wait_drain(100);
      check("final_queues_empty", q_a.size() + q_b.size() + q_iss.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: WAIT-state cycles before a transaction is abandoned, legal range 1..65535.
REQ-002 SHALL have parameter RESET_GRANT, default 1: port treated as last-granted out of reset (0 = A, 1 = B).
REQ-003 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports a_addr_i / b_addr_i, input, 16: host register address.
REQ-006 SHALL have ports a_wdata_i / b_wdata_i, input, 16: host write data.
REQ-007 SHALL have ports a_rw_i / b_rw_i, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have ports a_valid_i / b_valid_i, input, 1: host request strobe.
REQ-009 SHALL have ports a_ready_o / b_ready_o, output, 1: request slot empty.
REQ-010 SHALL have ports a_rdata_o / b_rdata_o, output, 16; a_rvalid_o / b_rvalid_o, output, 1; a_rerr_o / b_rerr_o, output, 1: response data, one-cycle response strobe, timeout flag.
REQ-011 SHALL have ports addr_o, wdata_o, rdata_o, output, 16 each; rw_o, valid_o, output, 1 each: request into head of register-bus chain.
REQ-012 SHALL have ports addr_i, wdata_i, rdata_i, input, 16 each; rw_i, valid_i, input, 1 each: return from tail of chain.

Function
REQ-013 SHALL accept a host request when x_valid_i && x_ready_o, latching addr/wdata/rw into a one-entry slot; x_ready_o low from next cycle until that slot's response.
REQ-014 SHALL ignore x_valid_i while x_ready_o is low (no overwrite of a pending slot).
REQ-015 SHALL implement states IDLE, ISSUE, WAIT, RESPOND; one transaction outstanding at a time.
REQ-016 IDLE: if any slot pending, grant and go to ISSUE; both pending -> grant the port not last granted (round-robin).
REQ-017 ISSUE: drive valid_o=1 for exactly one cycle with the granted slot's addr_o/wdata_o/rw_o and rdata_o=16'h0000; go to WAIT.
REQ-018 WAIT: on valid_i, capture rdata_i, go to RESPOND; reads and writes both wait for return.
REQ-019 RESPOND: pulse granted x_rvalid_o for one cycle with captured data, x_rerr_o=0, clear slot (x_ready_o high same cycle), update last-grant, return to IDLE.
REQ-020 Best case: accept in cycle 0 -> valid_o in cycle 2; valid_i in cycle k -> x_rvalid_o in cycle k+1.
REQ-021 valid_i outside WAIT SHALL be ignored; valid_i during ISSUE cycle ignored.
REQ-022 Bus outputs other than valid_o SHALL hold their last value when valid_o=0; valid_o never asserted outside ISSUE.
REQ-023 Host request accepted during RESPOND of the other port SHALL be eligible in the following IDLE.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, clear both slots, last-grant = RESET_GRANT, timeout counter 0.
REQ-025 During reset: x_ready_o=1, x_rvalid_o=0, x_rerr_o=0, x_rdata_o=0, valid_o=0, rw_o=0, addr_o/wdata_o/rdata_o=0.
REQ-026 Reset mid-transaction SHALL drop the transaction with no response; late valid_i after release ignored (state IDLE).

Configuration
REQ-027 With BUS_ARBITER_TIMEOUT_EN defined: counter runs in WAIT; on reaching TIMEOUT with no valid_i, go to RESPOND with x_rdata_o=16'h0000, x_rerr_o=1; valid_i in the same cycle as expiry wins (normal response).
REQ-028 Without BUS_ARBITER_TIMEOUT_EN: no counter, WAIT lasts until valid_i, x_rerr_o tied 0.

Verification
REQ-029 A read addr 16'h0012, chain returns rdata_i=16'hBEEF 3 cycles after valid_o -> a_rvalid_o one cycle, a_rdata_o=16'hBEEF, a_rerr_o=0, a_ready_o high.
REQ-030 A and B valid same cycle after reset (RESET_GRANT=1) -> A issued first, B issued after A's RESPOND; repeat -> order B then A.
REQ-031 B write addr 16'h0003 wdata 16'h00FF -> valid_o one cycle with rw_o=1, addr_o=16'h0003, wdata_o=16'h00FF; b_rvalid_o only after valid_i.
REQ-032 Macro defined, TIMEOUT=8, chain never returns -> a_rvalid_o with a_rerr_o=1, a_rdata_o=0 after 8 WAIT cycles; next request served normally.
REQ-033 rst_n pulsed low during WAIT, then valid_i arrives -> no x_rvalid_o, both ready high, all outputs at reset values.
